// File: rtl/clkdiv_seq_pkg.sv
// Shared types for the CLKDIV reset/enable sequencer.
package clkdiv_seq_pkg;

  localparam int unsigned FAULT_CNT_W = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    DIV_RELEASE = 3'd2,
    SER_RELEASE = 3'd3,
    RUN         = 3'd4,
    FAULT       = 3'd5
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/clkdiv_reset_sequencer.sv
// Sequences CLKDIV and OSER10 reset release after stable PLL lock, and restarts
// the sequence on lock loss, soft restart or a stalled divided clock.
module clkdiv_reset_sequencer
  import clkdiv_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DIV_SETTLE_CYCLES  = 16,
  parameter int unsigned SER_SETTLE_CYCLES  = 16,
  parameter int unsigned WATCHDOG_CYCLES    = 32,
  parameter int unsigned CNT_W              = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   soft_restart,
  input  logic                   divclk_fb,
  output logic                   clkdiv_resetn,
  output logic                   oser_reset,
  output logic                   ready,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SER_LAST  = CNT_W'(SER_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(WATCHDOG_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_div_prev;
  logic                   r_resetn;
  logic                   r_oser;
  logic                   r_ready;
  logic [FAULT_CNT_W-1:0] r_fault_cnt;
  logic                   w_lock_s;
  logic                   w_div_s;
  logic                   w_div_rise;
  logic                   w_cnt_clr;

  sync2 u_sync_lock (.i_clk(clk), .i_rst(reset), .i_d(pll_lock),  .o_q(w_lock_s));
  sync2 u_sync_div  (.i_clk(clk), .i_rst(reset), .i_d(divclk_fb), .o_q(w_div_s));

  assign w_div_rise = w_div_s & ~r_div_prev;

  // Next-state decision; lock loss outranks soft restart once the divider is released.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) w_next = LOCK_STABLE;
      end
      LOCK_STABLE: begin
        if (!w_lock_s || soft_restart) w_next = WAIT_LOCK;
        else if (r_cnt == LOCK_LAST)   w_next = DIV_RELEASE;
      end
      DIV_RELEASE: begin
        if (!w_lock_s)              w_next = FAULT;
        else if (soft_restart)      w_next = WAIT_LOCK;
        else if (r_cnt == DIV_LAST) w_next = SER_RELEASE;
      end
      SER_RELEASE: begin
        if (!w_lock_s)              w_next = FAULT;
        else if (soft_restart)      w_next = WAIT_LOCK;
        else if (r_cnt == SER_LAST) w_next = RUN;
      end
      RUN: begin
        if (!w_lock_s)                            w_next = FAULT;
        else if (soft_restart)                    w_next = WAIT_LOCK;
        else if (!w_div_rise && r_cnt == WD_LAST) w_next = FAULT;
      end
      FAULT:   w_next = WAIT_LOCK;
      default: w_next = WAIT_LOCK;
    endcase
  end

  // Shared counter restarts on every state change; in RUN a divided-clock edge also kicks it.
  assign w_cnt_clr = (w_next != r_state) || (r_state == WAIT_LOCK) ||
                     ((r_state == RUN) && w_div_rise);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_div_prev  <= 1'b0;
      r_resetn    <= 1'b0;
      r_oser      <= 1'b1;
      r_ready     <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      r_div_prev <= w_div_s;
      // Outputs decode the state being entered so they change on the same edge.
      r_resetn   <= (w_next == DIV_RELEASE) || (w_next == SER_RELEASE) || (w_next == RUN);
      r_oser     <= !((w_next == SER_RELEASE) || (w_next == RUN));
      r_ready    <= (w_next == RUN);
      if ((w_next == FAULT) && (r_fault_cnt != '1))
        r_fault_cnt <= r_fault_cnt + FAULT_CNT_W'(1);
    end
  end

  assign clkdiv_resetn = r_resetn;
  assign oser_reset    = r_oser;
  assign ready         = r_ready;
  assign fault_count   = r_fault_cnt;

endmodule

// File: tb/tb_clkdiv_reset_sequencer.sv
// Self-checking bench: randomized directed sequence against a timing model of the sequencer.
module tb_clkdiv_reset_sequencer;

  localparam int SYNC_LAT = 2;
  localparam int LOCK_N   = 1024;
  localparam int DIV_N    = 16;
  localparam int SER_N    = 16;
  localparam int WD_N     = 32;
  // Small instance used to reach fault-count saturation quickly
  localparam int S_LOCK_N = 4;
  localparam int S_DIV_N  = 2;
  localparam int S_SER_N  = 2;
  localparam int S_WD_N   = 10;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       soft_restart;
  logic       divclk_fb;
  logic       clkdiv_resetn;
  logic       oser_reset;
  logic       ready;
  logic [7:0] fault_count;

  logic       s_lock;
  logic       s_soft;
  logic       s_div;
  logic       s_resetn;
  logic       s_oser;
  logic       s_ready;
  logic [7:0] s_fcnt;

  logic div_en;
  int   div_ph;
  int   now;
  int   n_pass;
  int   n_chk;

  clkdiv_reset_sequencer dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .soft_restart(soft_restart),
    .divclk_fb(divclk_fb), .clkdiv_resetn(clkdiv_resetn), .oser_reset(oser_reset),
    .ready(ready), .fault_count(fault_count)
  );

  clkdiv_reset_sequencer #(
    .LOCK_STABLE_CYCLES(S_LOCK_N), .DIV_SETTLE_CYCLES(S_DIV_N),
    .SER_SETTLE_CYCLES(S_SER_N), .WATCHDOG_CYCLES(S_WD_N), .CNT_W(11)
  ) dut_small (
    .clk(clk), .reset(reset), .pll_lock(s_lock), .soft_restart(s_soft),
    .divclk_fb(s_div), .clkdiv_resetn(s_resetn), .oser_reset(s_oser),
    .ready(s_ready), .fault_count(s_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divide-by-5 feedback clock, updated 2 time units after each hclk edge
  always @(posedge clk) begin
    #2;
    if (div_en) begin
      div_ph    = (div_ph == 4) ? 0 : div_ph + 1;
      divclk_fb = (div_ph < 2);
    end else begin
      divclk_fb = 1'b0;
    end
  end

  // Reference timing: an input changed just after edge e is first acted on at edge e+SYNC_LAT+1,
  // and each counting state lasts exactly its cycle parameter.
  function automatic int rel_div(input int lock_edge);
    return lock_edge + SYNC_LAT + 1 + LOCK_N;
  endfunction
  function automatic int rel_ser(input int lock_edge);
    return rel_div(lock_edge) + DIV_N;
  endfunction
  function automatic int rel_run(input int lock_edge);
    return rel_ser(lock_edge) + SER_N;
  endfunction
  // After a restart decided at edge f with lock held: one cycle out, one cycle in WAIT_LOCK.
  function automatic int run_after(input int f);
    return f + 2 + LOCK_N + DIV_N + SER_N;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic tick_to(input int t);
    while (now < t) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    int a, b, c, f, x, y, s, ser2, z, w, n, k, first, per;
    bit seen;
    reset = 1'b1; pll_lock = 1'b0; soft_restart = 1'b0; div_en = 1'b0; div_ph = 0;
    s_lock = 1'b0; s_soft = 1'b0; s_div = 1'b0;
    now = 0; n_pass = 0; n_chk = 0;

    tick(); tick();
    check("rst_resetn", 32'(clkdiv_resetn), 32'd0);
    check("rst_oser", 32'(oser_reset), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fcnt", 32'(fault_count), 32'd0);
    check("rst_small_oser", 32'(s_oser), 32'd1);
    check("rst_small_resetn", 32'(s_resetn), 32'd0);
    reset = 1'b0;
    repeat ($urandom_range(1, 8)) tick();

    // Lock rises, then glitches low inside LOCK_STABLE: count must restart
    a = now; pll_lock = 1'b1; div_en = 1'b1;
    c = a + SYNC_LAT + 1 + int'($urandom_range(400, 600));
    tick_to(c); pll_lock = 1'b0;
    tick_to(c + 2);
    check("glitch_resetn", 32'(clkdiv_resetn), 32'd0);
    b = now; pll_lock = 1'b1;
    tick_to(rel_div(a));
    check("glitch_no_release", 32'(clkdiv_resetn), 32'd0);
    tick_to(rel_div(b) - 1);
    check("div_before", 32'(clkdiv_resetn), 32'd0);
    tick();
    check("div_release", 32'(clkdiv_resetn), 32'd1);
    check("div_oser_held", 32'(oser_reset), 32'd1);
    tick_to(rel_ser(b) - 1);
    check("ser_before", 32'(oser_reset), 32'd1);
    tick();
    check("ser_release", 32'(oser_reset), 32'd0);
    check("ser_not_ready", 32'(ready), 32'd0);
    tick_to(rel_run(b) - 1);
    check("run_before", 32'(ready), 32'd0);
    tick();
    check("run_ready", 32'(ready), 32'd1);
    check("run_resetn", 32'(clkdiv_resetn), 32'd1);
    check("run_fcnt", 32'(fault_count), 32'd0);

    // Stall the divided clock: watchdog fires 30..34 cycles after the stop
    repeat ($urandom_range(3, 40)) tick();
    check("run_hold", 32'(ready), 32'd1);
    div_en = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < WD_N + 8) begin
      tick(); n++;
      if (!ready) seen = 1'b1;
    end
    check("wd_fired", 32'(seen), 32'd1);
    check("wd_latency", 32'((n >= WD_N - 2) && (n <= WD_N + 2)), 32'd1);
    f = now;
    check("wd_resetn", 32'(clkdiv_resetn), 32'd0);
    check("wd_oser", 32'(oser_reset), 32'd1);
    check("wd_fcnt", 32'(fault_count), 32'd1);
    div_en = 1'b1;
    tick_to(run_after(f) - 1);
    check("wd_rerun_before", 32'(ready), 32'd0);
    tick();
    check("wd_rerun_ready", 32'(ready), 32'd1);

    // Lock loss in RUN: resets reassert on the third edge
    repeat ($urandom_range(1, 10)) tick();
    x = now; pll_lock = 1'b0;
    tick_to(x + 2);
    check("ll_still_ready", 32'(ready), 32'd1);
    tick();
    check("ll_ready", 32'(ready), 32'd0);
    check("ll_resetn", 32'(clkdiv_resetn), 32'd0);
    check("ll_oser", 32'(oser_reset), 32'd1);
    check("ll_fcnt", 32'(fault_count), 32'd2);
    y = x + 3 + int'($urandom_range(2, 6));
    tick_to(y); pll_lock = 1'b1;
    tick_to(rel_div(y) - 1);
    check("relock_before", 32'(clkdiv_resetn), 32'd0);
    tick();
    check("relock_release", 32'(clkdiv_resetn), 32'd1);

    // Soft restart in SER_RELEASE is not counted
    tick_to(rel_ser(y) + 2);
    check("soft_pre_oser", 32'(oser_reset), 32'd0);
    soft_restart = 1'b1;
    tick(); s = now;
    soft_restart = 1'b0;
    check("soft_oser", 32'(oser_reset), 32'd1);
    check("soft_resetn", 32'(clkdiv_resetn), 32'd0);
    check("soft_fcnt", 32'(fault_count), 32'd2);
    ser2 = s + 1 + LOCK_N + DIV_N;
    tick_to(ser2 - 1);
    check("soft_rerun_before", 32'(oser_reset), 32'd1);
    tick();
    check("soft_rerun_ser", 32'(oser_reset), 32'd0);
    // Soft restart coinciding with synced lock loss counts as a fault
    z = ser2 + 2;
    tick_to(z); pll_lock = 1'b0;
    tick_to(z + 2); soft_restart = 1'b1;
    tick();
    soft_restart = 1'b0;
    check("both_fcnt", 32'(fault_count), 32'd3);
    check("both_oser", 32'(oser_reset), 32'd1);

    // Saturation on the small instance: divided clock never runs, so RUN always times out
    a = now; s_lock = 1'b1;
    first = a + SYNC_LAT + 1 + S_LOCK_N + S_DIV_N + S_SER_N + S_WD_N;
    per   = 2 + S_LOCK_N + S_DIV_N + S_SER_N + S_WD_N;
    k = int'($urandom_range(50, 200));
    tick_to(first + per * (k - 1) - 1);
    check("sat_before_k", 32'(s_fcnt), 32'(k - 1));
    tick();
    check("sat_at_k", 32'(s_fcnt), 32'(k));
    tick_to(first + per * 299 + 5);
    check("sat_255", 32'(s_fcnt), 32'd255);

    // Async reset in the middle of DIV_RELEASE
    w = now; pll_lock = 1'b1;
    tick_to(rel_div(w) + 3);
    check("mid_div_resetn", 32'(clkdiv_resetn), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("arst_resetn", 32'(clkdiv_resetn), 32'd0);
    check("arst_oser", 32'(oser_reset), 32'd1);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_fcnt", 32'(fault_count), 32'd0);
    check("arst_small_fcnt", 32'(s_fcnt), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("post_arst_resetn", 32'(clkdiv_resetn), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
